// File: rtl/dispatch_scheduler.sv
// dispatch_scheduler
//
// Pops one entry at a time from the Evac/Shelter/Food queue front-end and reserves
// one of four rescue teams for it. The captured entry is then offered downstream on
// a valid/ready handshake. Each team has an 8-bit mission timer. The timer is loaded
// on acceptance, and the team is freed when the timer expires or the team is
// returned early.
//
// Ports
//   Clock, Reset_Queue            clock and synchronous active-high reset
//   Enable                        permits a new dispatch to start from IDLE
//   Evac_Empty, Shelter_Valid,    queue status flags from the front-end
//   Food_Valid, Select_Shelter
//   Head_Zone, Head_Priority      current head entry (muxed evac-first upstream)
//   Serve                         one-cycle pop strobe back to the front-end
//   Dispatch_Valid/Ready          downstream offer handshake
//   Dispatch_Zone/Priority/       captured entry, source (00 food, 01 shelter,
//   Source/Team                   10 evac) and reserved team index
//   Team_Return, Team_Return_Id   early-return strobe for one team
//   Team_Busy, All_Busy           registered team occupancy
//   Dispatch_Count                accepted dispatches, saturating
module dispatch_scheduler #(
  parameter logic [7:0] MISSION_TIME = 8'd40
) (
  input  logic        Clock,
  input  logic        Reset_Queue,
  input  logic        Enable,
  input  logic        Evac_Empty,
  input  logic        Shelter_Valid,
  input  logic        Food_Valid,
  input  logic        Select_Shelter,
  input  logic [7:0]  Head_Zone,
  input  logic [1:0]  Head_Priority,
  output logic        Serve,
  output logic        Dispatch_Valid,
  input  logic        Dispatch_Ready,
  output logic [7:0]  Dispatch_Zone,
  output logic [1:0]  Dispatch_Priority,
  output logic [1:0]  Dispatch_Source,
  output logic [1:0]  Dispatch_Team,
  input  logic        Team_Return,
  input  logic [1:0]  Team_Return_Id,
  output logic [3:0]  Team_Busy,
  output logic        All_Busy,
  output logic [15:0] Dispatch_Count
);

  typedef enum logic [1:0] {StIdle, StServe, StOffer} state_e;

  state_e          state_q;
  logic [3:0]      busy_q, busy_d;
  logic [3:0][7:0] timer_q, timer_d;
  logic            all_busy_q;
  logic            valid_q;
  logic [7:0]      zone_q;
  logic [1:0]      prio_q;
  logic [1:0]      src_q;
  logic [1:0]      team_q;
  logic [15:0]     dispatch_count_q;

  logic       work;
  logic       free;
  logic [1:0] pick;
  logic       ret_ok;
  logic       accept;

  assign work   = ~Evac_Empty | Shelter_Valid | Food_Valid;
  assign free   = ~&busy_q;
  assign accept = (state_q == StOffer) & Dispatch_Ready;

  // A return aimed at the team still waiting in OFFER would free a team whose
  // mission has not started yet, so that case is ignored.
  assign ret_ok = Team_Return & busy_q[Team_Return_Id] &
                  ~((state_q == StOffer) & (team_q == Team_Return_Id));

  // Lowest-index free team. The loop runs downward so the lowest index wins.
  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!busy_q[i]) pick = 2'(i);
    end
  end

  always_comb begin
    busy_d  = busy_q;
    timer_d = timer_q;
    for (int i = 0; i < 4; i++) begin
      if (timer_q[i] != 8'd0) begin
        timer_d[i] = timer_q[i] - 8'd1;
        if (timer_q[i] == 8'd1) busy_d[i] = 1'b0;
      end
    end
    // An expiry and a return on the same team and edge both clear it, so they
    // collapse to a single clear.
    if (ret_ok) begin
      busy_d[Team_Return_Id]  = 1'b0;
      timer_d[Team_Return_Id] = 8'd0;
    end
    // The reserved team sits at timer 0 and stays busy until acceptance.
    if ((state_q == StServe) && work) busy_d[pick] = 1'b1;
    if (accept) timer_d[team_q] = MISSION_TIME;
  end

  always_ff @(posedge Clock) begin
    if (Reset_Queue) begin
      state_q          <= StIdle;
      busy_q           <= 4'd0;
      timer_q          <= '0;
      all_busy_q       <= 1'b0;
      valid_q          <= 1'b0;
      zone_q           <= 8'd0;
      prio_q           <= 2'd0;
      src_q            <= 2'd0;
      team_q           <= 2'd0;
      dispatch_count_q <= 16'd0;
    end else begin
      busy_q     <= busy_d;
      timer_q    <= timer_d;
      all_busy_q <= &busy_d;
      unique case (state_q)
        StIdle: begin
          if (Enable && work && free) state_q <= StServe;
        end
        StServe: begin
          // Capture happens on the same edge as the pop, so head changes
          // made during IDLE cannot corrupt the captured entry.
          if (work) begin
            zone_q  <= Head_Zone;
            prio_q  <= Head_Priority;
            src_q   <= !Evac_Empty ? 2'b10 : (Select_Shelter ? 2'b01 : 2'b00);
            team_q  <= pick;
            valid_q <= 1'b1;
            state_q <= StOffer;
          end else begin
            state_q <= StIdle;
          end
        end
        StOffer: begin
          if (Dispatch_Ready) begin
            valid_q <= 1'b0;
            if (dispatch_count_q != 16'hFFFF) dispatch_count_q <= dispatch_count_q + 16'd1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Serve             = (state_q == StServe) & work;
  assign Dispatch_Valid    = valid_q;
  assign Dispatch_Zone     = zone_q;
  assign Dispatch_Priority = prio_q;
  assign Dispatch_Source   = src_q;
  assign Dispatch_Team     = team_q;
  assign Team_Busy         = busy_q;
  assign All_Busy          = all_busy_q;
  assign Dispatch_Count    = dispatch_count_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler. Two instances share the stimulus: dut with
// the default mission time, and dut_t3 with MISSION_TIME = 3 for the expiry check.
// A small queue model pops one entry per observed Serve pulse.
module tb_dispatch_scheduler;

  logic Clock;
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       Reset_Queue, Enable, Evac_Empty, Shelter_Valid, Food_Valid, Select_Shelter;
  logic [7:0] Head_Zone;
  logic [1:0] Head_Priority;
  logic       Dispatch_Ready, Team_Return;
  logic [1:0] Team_Return_Id;

  logic        Serve, Dispatch_Valid, All_Busy;
  logic [7:0]  Dispatch_Zone;
  logic [1:0]  Dispatch_Priority, Dispatch_Source, Dispatch_Team;
  logic [3:0]  Team_Busy;
  logic [15:0] Dispatch_Count;

  logic        s_serve, s_valid, s_all_busy;
  logic [7:0]  s_zone;
  logic [1:0]  s_prio, s_source, s_team;
  logic [3:0]  s_busy;
  logic [15:0] s_count;

  dispatch_scheduler dut (
    .Clock(Clock), .Reset_Queue(Reset_Queue), .Enable(Enable),
    .Evac_Empty(Evac_Empty), .Shelter_Valid(Shelter_Valid), .Food_Valid(Food_Valid),
    .Select_Shelter(Select_Shelter), .Head_Zone(Head_Zone), .Head_Priority(Head_Priority),
    .Serve(Serve), .Dispatch_Valid(Dispatch_Valid), .Dispatch_Ready(Dispatch_Ready),
    .Dispatch_Zone(Dispatch_Zone), .Dispatch_Priority(Dispatch_Priority),
    .Dispatch_Source(Dispatch_Source), .Dispatch_Team(Dispatch_Team),
    .Team_Return(Team_Return), .Team_Return_Id(Team_Return_Id),
    .Team_Busy(Team_Busy), .All_Busy(All_Busy), .Dispatch_Count(Dispatch_Count)
  );

  dispatch_scheduler #(.MISSION_TIME(8'd3)) dut_t3 (
    .Clock(Clock), .Reset_Queue(Reset_Queue), .Enable(Enable),
    .Evac_Empty(Evac_Empty), .Shelter_Valid(Shelter_Valid), .Food_Valid(Food_Valid),
    .Select_Shelter(Select_Shelter), .Head_Zone(Head_Zone), .Head_Priority(Head_Priority),
    .Serve(s_serve), .Dispatch_Valid(s_valid), .Dispatch_Ready(Dispatch_Ready),
    .Dispatch_Zone(s_zone), .Dispatch_Priority(s_prio),
    .Dispatch_Source(s_source), .Dispatch_Team(s_team),
    .Team_Return(Team_Return), .Team_Return_Id(Team_Return_Id),
    .Team_Busy(s_busy), .All_Busy(s_all_busy), .Dispatch_Count(s_count)
  );

  int         n_assert, n_fail;
  int         evac_n, shelter_n, food_n, serve_cnt, k;
  bit         pop_pending, seen, stable;
  logic [1:0] teams [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_flags();
    Evac_Empty     = (evac_n == 0);
    Shelter_Valid  = (shelter_n > 0);
    Food_Valid     = (food_n > 0);
    Select_Shelter = (shelter_n > 0);
  endtask

  // Sample Serve before the edge, then apply the pop after the edge so the queue
  // flags change only once the scheduler has captured the head.
  task automatic cyc();
    #1;
    if (Serve) begin
      pop_pending = 1'b1;
      serve_cnt++;
    end
    @(negedge Clock);
    if (pop_pending) begin
      if (evac_n > 0) evac_n--;
      else if (shelter_n > 0) shelter_n--;
      else if (food_n > 0) food_n--;
      pop_pending = 1'b0;
    end
    drive_flags();
    #1;
  endtask

  task automatic do_reset();
    Reset_Queue    = 1'b1;
    evac_n         = 0;
    shelter_n      = 0;
    food_n         = 0;
    Dispatch_Ready = 1'b0;
    Team_Return    = 1'b0;
    drive_flags();
    cyc();
    cyc();
    pop_pending = 1'b0;
    serve_cnt   = 0;
    Reset_Queue = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (Dispatch_Valid) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    if (Dispatch_Valid) found = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_assert = 0; n_fail = 0; serve_cnt = 0; pop_pending = 1'b0;
    Enable = 1'b0; Head_Zone = 8'h00; Head_Priority = 2'b00; Team_Return_Id = 2'd0;
    evac_n = 0; shelter_n = 0; food_n = 0;
    @(negedge Clock);

    // Reset state
    do_reset();
    chk("rst_serve", Serve, 0);
    chk("rst_valid", Dispatch_Valid, 0);
    chk("rst_busy", Team_Busy, 0);
    chk("rst_all_busy", All_Busy, 0);
    chk("rst_count", Dispatch_Count, 0);
    chk("rst_zone", Dispatch_Zone, 0);

    // Single evac item
    Enable = 1'b1; evac_n = 1; Head_Zone = 8'h21; Head_Priority = 2'b11;
    drive_flags();
    #1;
    chk("t1_serve_idle", Serve, 0);
    cyc();
    chk("t1_serve_hi", Serve, 1);
    cyc();
    chk("t1_serve_one_cycle", Serve, 0);
    chk("t1_valid", Dispatch_Valid, 1);
    chk("t1_zone", Dispatch_Zone, 8'h21);
    chk("t1_prio", Dispatch_Priority, 2'b11);
    chk("t1_source", Dispatch_Source, 2'b10);
    chk("t1_team", Dispatch_Team, 0);
    chk("t1_busy", Team_Busy, 4'b0001);
    Dispatch_Ready = 1'b1;
    cyc();
    chk("t1_count", Dispatch_Count, 1);
    chk("t1_valid_drop", Dispatch_Valid, 0);
    chk("t1_serves", serve_cnt, 1);

    // Pool saturation with five shelter items
    do_reset();
    shelter_n = 5; Head_Zone = 8'h40; Head_Priority = 2'b01; Dispatch_Ready = 1'b1;
    drive_flags();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      if (Dispatch_Valid) begin
        if (k < 4) teams[k] = Dispatch_Team;
        k++;
      end
      cyc();
    end
    chk("t2_num_dispatch", k, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_team%0d", i), teams[i], i);
    chk("t2_busy", Team_Busy, 4'b1111);
    chk("t2_all_busy", All_Busy, 1);
    chk("t2_serves", serve_cnt, 4);
    chk("t2_count", Dispatch_Count, 4);
    Team_Return = 1'b1; Team_Return_Id = 2'd2;
    cyc();
    Team_Return = 1'b0;
    chk("t2_busy_after_ret", Team_Busy, 4'b1011);
    chk("t2_all_busy_after_ret", All_Busy, 0);
    wait_valid(8, seen);
    chk("t2_fifth_seen", seen, 1);
    chk("t2_fifth_team", Dispatch_Team, 2);
    chk("t2_fifth_source", Dispatch_Source, 2'b01);
    cyc();
    chk("t2_count5", Dispatch_Count, 5);

    // Timer expiry on the MISSION_TIME = 3 instance
    do_reset();
    food_n = 1; Dispatch_Ready = 1'b1;
    drive_flags();
    wait_valid(6, seen);
    chk("t3_seen", s_valid, 1);
    chk("t3_source", s_source, 2'b00);
    cyc();
    chk("t3_busy_n", s_busy[0], 1);
    chk("t3_count", s_count, 1);
    cyc();
    chk("t3_busy_n1", s_busy[0], 1);
    cyc();
    chk("t3_busy_n2", s_busy[0], 1);
    cyc();
    chk("t3_busy_n3", s_busy[0], 0);
    chk("t3_long_busy", Team_Busy[0], 1);

    // Backpressure while more evac items arrive
    do_reset();
    evac_n = 1; Head_Zone = 8'h5A; Head_Priority = 2'b01; Dispatch_Ready = 1'b0;
    drive_flags();
    wait_valid(6, seen);
    chk("t4_seen", seen, 1);
    evac_n = 3; Head_Zone = 8'h77; Head_Priority = 2'b10;
    drive_flags();
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      stable &= Dispatch_Valid && (Dispatch_Zone == 8'h5A) && (Dispatch_Priority == 2'b01) &&
                (Dispatch_Source == 2'b10) && (Dispatch_Team == 2'd0);
    end
    chk("t4_stable", stable, 1);
    chk("t4_serves", serve_cnt, 1);
    chk("t4_count_hold", Dispatch_Count, 0);
    Dispatch_Ready = 1'b1;
    cyc();
    chk("t4_count", Dispatch_Count, 1);
    chk("t4_valid_drop", Dispatch_Valid, 0);

    // Work vanishes in the SERVE cycle
    do_reset();
    food_n = 1;
    drive_flags();
    cyc();
    chk("t5_serve_pre", Serve, 1);
    food_n = 0;
    drive_flags();
    #1;
    chk("t5_serve_cancel", Serve, 0);
    cyc();
    chk("t5_busy", Team_Busy, 0);
    chk("t5_valid", Dispatch_Valid, 0);
    cyc();
    chk("t5_serves", serve_cnt, 0);
    chk("t5_idle_valid", Dispatch_Valid, 0);

    // Reset during OFFER
    do_reset();
    evac_n = 1; Head_Zone = 8'hC3; Dispatch_Ready = 1'b0;
    drive_flags();
    wait_valid(6, seen);
    chk("t6_seen", seen, 1);
    Reset_Queue = 1'b1;
    cyc();
    chk("t6_valid", Dispatch_Valid, 0);
    chk("t6_busy", Team_Busy, 0);
    chk("t6_zone", Dispatch_Zone, 0);
    Reset_Queue = 1'b0; evac_n = 0; pop_pending = 1'b0; serve_cnt = 0;
    drive_flags();
    cyc();

    // Count saturation
    force dut.dispatch_count_q = 16'hFFFF;
    #1;
    release dut.dispatch_count_q;
    evac_n = 1; Dispatch_Ready = 1'b1;
    drive_flags();
    wait_valid(6, seen);
    chk("t7_seen", seen, 1);
    cyc();
    chk("t7_count_sat", Dispatch_Count, 16'hFFFF);
    chk("t7_busy", Team_Busy[0], 1);
    chk("t7_serves", serve_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_scheduler.md
# dispatch_scheduler

Sequences the Evac/Shelter/Food queue front-end against a pool of 4 rescue teams. When a team is free and any queue holds work, it issues a one-cycle `Serve` pulse to the queue block. In that same cycle it captures the served head entry and reserves the team, then offers the dispatch downstream on a valid/ready handshake. It sits between the queue front-end (`Serve`, head zone/priority, empty/valid flags) and the field-dispatch interface, and tracks team occupancy with per-team mission timers.

## Interface
- `MISSION_TIME`, default 8'd40: cycles a team stays busy after its dispatch is accepted, unless returned early. Legal range 1..255.

Ports:
- `Clock`  in  1  single system clock; all state updates on the rising edge.
- `Reset_Queue`  in  1  synchronous, active-high reset.
- `Enable`  in  1  permits new dispatches to start. In-flight SERVE/OFFER always complete.
- `Evac_Empty`  in  1  evac queue empty flag.
- `Shelter_Valid`  in  1  shelter queue head valid.
- `Food_Valid`  in  1  food queue head valid.
- `Select_Shelter`  in  1  final selector choice: 1 = shelter, 0 = food.
- `Head_Zone`  in  8  current head zone, muxed evac-first by the front-end.
- `Head_Priority`  in  2  current head priority.
- `Serve`  out  1  one-cycle pop strobe to the queue front-end.
- `Dispatch_Valid`  out  1  dispatch offer valid.
- `Dispatch_Ready`  in  1  downstream accepts the offer.
- `Dispatch_Zone`  out  8  captured zone.
- `Dispatch_Priority`  out  2  captured priority.
- `Dispatch_Source`  out  2  00 food, 01 shelter, 10 evac (same encoding as Resource_line).
- `Dispatch_Team`  out  2  reserved team index.
- `Team_Return`  in  1  early-return strobe.
- `Team_Return_Id`  in  2  team being returned.
- `Team_Busy`  out  4  per-team busy bitmap.
- `All_Busy`  out  1  `&Team_Busy`.
- `Dispatch_Count`  out  16  accepted dispatches, saturating at 16'hFFFF.

## Operation
- `work` = `~Evac_Empty | Shelter_Valid | Food_Valid`.
- `free` = `~&Team_Busy`.
- `pick` = lowest-index team whose busy bit is 0.
- FSM states: IDLE, SERVE, OFFER. State is registered; outputs decode from the state.
- **IDLE**
  - If `Enable & work & free`, go to SERVE.
  - Otherwise stay in IDLE.
- **SERVE**
  - `Serve` = `work`, asserted combinationally in this state only.
  - If `work` is 1 at the edge:
    - Capture `Head_Zone` and `Head_Priority`.
    - Capture source: 10 if `~Evac_Empty`, else 01 if `Select_Shelter`, else 00.
    - Capture `pick` into `Dispatch_Team`.
    - Set `Team_Busy[pick]`.
    - Go to OFFER.
  - If `work` has dropped (cancel or reset upstream), go to IDLE with no pop and no reservation.
- **OFFER**
  - `Dispatch_Valid` = 1. All `Dispatch_*` fields stay stable until acceptance.
  - On `Dispatch_Ready`: load that team's timer with `MISSION_TIME`, increment `Dispatch_Count` (saturating), go to IDLE.
  - `Dispatch_Ready` is ignored outside OFFER.
- **Team timers** (8 bits each)
  - While nonzero, a timer decrements every cycle, independent of `Enable`.
  - The edge on which a timer goes from 1 to 0 also clears that team's busy bit.
  - A reserved team that has not yet been accepted has timer 0 and stays busy; it is not a timeout.
- **Team_Return**
  - Clears busy and the timer of `Team_Return_Id` on the next edge.
  - Ignored if that team is idle.
  - Ignored if that team is the one currently reserved in OFFER.
  - A return and a timer expiry on the same team and edge give a single clear.
- **Reset**
  - State to IDLE.
  - `Serve`, `Dispatch_Valid`, and all `Dispatch_*` fields to 0.
  - `Team_Busy` 0, timers 0, `Dispatch_Count` 0, `All_Busy` 0.
  - Reset has priority over every other event, including mid-SERVE or mid-OFFER. Any offer in progress is dropped.

## Timing
- Minimum dispatch period is 3 cycles (IDLE, SERVE, OFFER) with `Dispatch_Ready` held high.
- `Serve` is never high on two consecutive cycles.
- Data is captured on the same edge that the queue pops, so head changes between IDLE and SERVE are harmless.
- A team freed on edge N can be picked when IDLE evaluates in cycle N+1.
- `Team_Busy` and `All_Busy` are registered outputs.
- With `MISSION_TIME` = T and no early return, the team is busy for exactly T cycles after the accept edge.
- If `Enable` falls during SERVE or OFFER, the current dispatch completes, then the FSM holds in IDLE.

## Test plan
- **Reset:** reset, then insert an evac item (zone 8'h21, priority 2'b11).
  - Expect `Serve` high for exactly 1 cycle, 1 cycle after IDLE sees `Evac_Empty`=0.
  - Expect `Dispatch_Valid` with zone 21, source 10, team 0.
  - With `Dispatch_Ready`=1, expect `Dispatch_Count`=1.
- **Pool saturation:** 5 shelter items, ready held high.
  - Expect teams 0,1,2,3 dispatched, then `All_Busy`=1 and no 5th `Serve`.
  - Pulse `Team_Return`, id 2; expect the 5th dispatch on team 2.
- **Timer expiry:** `MISSION_TIME`=3, single food item accepted at edge N.
  - Expect `Team_Busy[0]` to clear at edge N+3.
- **Backpressure:** `Dispatch_Ready` held low for 10 cycles in OFFER while new evac items are inserted.
  - Expect the fields stable, no extra `Serve`, and count unchanged until ready rises.
- **Vanishing work:** the only item is cancelled in the cycle the FSM enters SERVE.
  - Expect `Serve`=0, no team reserved, return to IDLE.
- **Reset mid-operation and saturation:** assert `Reset_Queue` during OFFER.
  - Expect `Dispatch_Valid`=0 and `Team_Busy`=0 next cycle.
  - Separately, force `Dispatch_Count` to FFFF; another accept keeps it at FFFF.
